arith_issue_queue: RTL and testbench

Age-ordered reservation station for the arithmetic cluster. It buffers renamed arithmetic instructions from dispatch and captures operand and flag values from the common data bus (CDB) as they are produced. Each cycle it issues the oldest fully-ready entry, through registered outputs, into `arithmetic_pipeline`, the stage directly downstream.

---
 rtl/ooo_pkg.sv | 33 +++
 rtl/iq_operand_slot.sv | 35 +++
 rtl/arith_issue_queue.sv | 166 ++++++++++++++++
 tb/tb_arith_issue_queue.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared widths and record types for the out-of-order arithmetic cluster.
package ooo_pkg;

  localparam int OPC_W   = 4;
  localparam int TAG_W   = 5;
  localparam int DATA_W  = 8;
  localparam int ROB_W   = 5;
  localparam int ARCH_W  = 8;
  localparam int CNT_W   = 4;
  localparam int NUM_SRC = 3;

  // Source operand positions within an entry.
  localparam int SRC_A = 0;
  localparam int SRC_B = 1;
  localparam int SRC_F = 2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic              rdy;
    logic [DATA_W-1:0] val;
  } operand_t;

  // Operand state lives in iq_operand_slot instances, indexed alongside this record.
  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [ROB_W-1:0]  rob_entry;
    logic [TAG_W-1:0]  dest_reg;
    logic [TAG_W-1:0]  flag_reg;
    logic [ARCH_W-1:0] arch_dest_regs;
  } iq_entry_t;

endpackage

// File: rtl/iq_operand_slot.sv
// One {tag, rdy, val} source operand: load from dispatch or a shifting
// neighbour, then capture a matching CDB broadcast on top of the loaded value.
module iq_operand_slot
  import ooo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  operand_t          load_data,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output operand_t          q
);

  operand_t base;
  operand_t nxt;

  // Waking the loaded value gives dispatch bypass and wake-while-shifting for free.
  always_comb begin
    base = load ? load_data : q;
    nxt  = base;
    if (cdb_valid && !base.rdy && (base.tag == cdb_tag)) begin
      nxt.rdy = 1'b1;
      nxt.val = cdb_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= nxt;
  end

endmodule

// File: rtl/arith_issue_queue.sv
// Age-ordered, compacting reservation station that issues the oldest fully
// ready arithmetic instruction per cycle through a registered bundle.
module arith_issue_queue
  import ooo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OPC_W-1:0]  disp_opcode,
  input  logic [ROB_W-1:0]  disp_ROB_entry,
  input  logic [TAG_W-1:0]  disp_dest_reg,
  input  logic [TAG_W-1:0]  disp_flag_reg,
  input  logic [ARCH_W-1:0] disp_arch_dest_regs,
  input  logic [TAG_W-1:0]  disp_a_tag,
  input  logic [TAG_W-1:0]  disp_b_tag,
  input  logic [TAG_W-1:0]  disp_f_tag,
  input  logic              disp_a_rdy,
  input  logic              disp_b_rdy,
  input  logic              disp_f_rdy,
  input  logic [DATA_W-1:0] disp_a_val,
  input  logic [DATA_W-1:0] disp_b_val,
  input  logic [DATA_W-1:0] disp_f_val,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_dest_reg,
  input  logic [TAG_W-1:0]  cdb_flag_reg,
  input  logic [DATA_W-1:0] cdb_result_val,
  input  logic [DATA_W-1:0] cdb_result_flags,
  output logic [OPC_W-1:0]  opcode,
  output logic [ROB_W-1:0]  ROB_entry,
  output logic [TAG_W-1:0]  dest_reg,
  output logic [TAG_W-1:0]  flag_reg,
  output logic [DATA_W-1:0] op_a_val,
  output logic [DATA_W-1:0] op_b_val,
  output logic [DATA_W-1:0] flags_val,
  output logic [ARCH_W-1:0] arch_dest_regs,
  output logic              instr_valid,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W = $clog2(DEPTH);

  iq_entry_t        ent_q   [DEPTH];
  iq_entry_t        ent_d   [DEPTH];
  operand_t         opnd_q  [NUM_SRC][DEPTH];
  operand_t         opnd_ld [NUM_SRC][DEPTH];
  logic [DEPTH-1:0] opnd_load;
  operand_t         disp_src [NUM_SRC];

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] wr_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             issue;
  logic             disp_fire;

  // Ready depends only on occupancy, keeping select off the ready path.
  assign disp_ready = (count_q < CNT_W'(DEPTH));
  assign count      = count_q;
  assign disp_fire  = disp_valid && disp_ready && !flush;

  assign disp_src[SRC_A] = '{tag: disp_a_tag, rdy: disp_a_rdy, val: disp_a_val};
  assign disp_src[SRC_B] = '{tag: disp_b_tag, rdy: disp_b_rdy, val: disp_b_val};
  assign disp_src[SRC_F] = '{tag: disp_f_tag, rdy: disp_f_rdy, val: disp_f_val};

  // Scanning from the top lets the lowest (oldest) ready index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    issue   = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].valid && opnd_q[SRC_A][i].rdy && opnd_q[SRC_B][i].rdy &&
          opnd_q[SRC_F][i].rdy) begin
        issue   = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Compaction: entries at or above the selected one take their upper neighbour;
  // dispatch lands just above the surviving entries.
  always_comb begin
    wr_idx = count_q - CNT_W'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      int up;
      up           = (i == DEPTH - 1) ? i : i + 1;
      ent_d[i]     = ent_q[i];
      opnd_load[i] = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) opnd_ld[k][i] = opnd_q[k][i];

      if (disp_fire && (wr_idx == CNT_W'(i))) begin
        ent_d[i] = '{valid: 1'b1, opcode: disp_opcode, rob_entry: disp_ROB_entry,
                     dest_reg: disp_dest_reg, flag_reg: disp_flag_reg,
                     arch_dest_regs: disp_arch_dest_regs};
        opnd_load[i] = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) opnd_ld[k][i] = disp_src[k];
      end else if (issue && (i >= int'(sel_idx))) begin
        if (i == DEPTH - 1) begin
          ent_d[i] = '0;
        end else begin
          ent_d[i]     = ent_q[up];
          opnd_load[i] = 1'b1;
          for (int k = 0; k < NUM_SRC; k++) opnd_ld[k][i] = opnd_q[k][up];
        end
      end

      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      iq_operand_slot u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (opnd_load[i]),
        .load_data (opnd_ld[k][i]),
        .cdb_valid (cdb_valid),
        .cdb_tag   ((k == SRC_F) ? cdb_flag_reg : cdb_dest_reg),
        .cdb_val   ((k == SRC_F) ? cdb_result_flags : cdb_result_val),
        .q         (opnd_q[k][i])
      );
    end
  end

  // NOTE: the entry array is only DEPTH records, so it is reset outright rather than just its valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= flush ? '0 : (count_q + CNT_W'(disp_fire) - CNT_W'(issue));
    end
  end

  // Issue register: data holds between issues; flush squashes a same-cycle issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid    <= 1'b0;
      opcode         <= '0;
      ROB_entry      <= '0;
      dest_reg       <= '0;
      flag_reg       <= '0;
      op_a_val       <= '0;
      op_b_val       <= '0;
      flags_val      <= '0;
      arch_dest_regs <= '0;
    end else begin
      instr_valid <= issue && !flush;
      if (issue && !flush) begin
        opcode         <= ent_q[sel_idx].opcode;
        ROB_entry      <= ent_q[sel_idx].rob_entry;
        dest_reg       <= ent_q[sel_idx].dest_reg;
        flag_reg       <= ent_q[sel_idx].flag_reg;
        arch_dest_regs <= ent_q[sel_idx].arch_dest_regs;
        op_a_val       <= opnd_q[SRC_A][sel_idx].val;
        op_b_val       <= opnd_q[SRC_B][sel_idx].val;
        flags_val      <= opnd_q[SRC_F][sel_idx].val;
      end
    end
  end

endmodule

// File: tb/tb_arith_issue_queue.sv
// Self-checking bench for arith_issue_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_arith_issue_queue;
  import ooo_pkg::*;

  localparam int DEPTH = 4;

  logic              clk, rst_n, flush;
  logic              disp_valid, disp_ready;
  logic [OPC_W-1:0]  disp_opcode;
  logic [ROB_W-1:0]  disp_ROB_entry;
  logic [TAG_W-1:0]  disp_dest_reg, disp_flag_reg;
  logic [ARCH_W-1:0] disp_arch_dest_regs;
  logic [TAG_W-1:0]  disp_a_tag, disp_b_tag, disp_f_tag;
  logic              disp_a_rdy, disp_b_rdy, disp_f_rdy;
  logic [DATA_W-1:0] disp_a_val, disp_b_val, disp_f_val;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_dest_reg, cdb_flag_reg;
  logic [DATA_W-1:0] cdb_result_val, cdb_result_flags;
  logic [OPC_W-1:0]  opcode;
  logic [ROB_W-1:0]  ROB_entry;
  logic [TAG_W-1:0]  dest_reg, flag_reg;
  logic [DATA_W-1:0] op_a_val, op_b_val, flags_val;
  logic [ARCH_W-1:0] arch_dest_regs;
  logic              instr_valid;
  logic [CNT_W-1:0]  count;

  int checks;
  int errors;

  arith_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_ROB_entry(disp_ROB_entry),
    .disp_dest_reg(disp_dest_reg), .disp_flag_reg(disp_flag_reg),
    .disp_arch_dest_regs(disp_arch_dest_regs),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_f_tag(disp_f_tag),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy), .disp_f_rdy(disp_f_rdy),
    .disp_a_val(disp_a_val), .disp_b_val(disp_b_val), .disp_f_val(disp_f_val),
    .cdb_valid(cdb_valid), .cdb_dest_reg(cdb_dest_reg), .cdb_flag_reg(cdb_flag_reg),
    .cdb_result_val(cdb_result_val), .cdb_result_flags(cdb_result_flags),
    .opcode(opcode), .ROB_entry(ROB_entry), .dest_reg(dest_reg), .flag_reg(flag_reg),
    .op_a_val(op_a_val), .op_b_val(op_b_val), .flags_val(flags_val),
    .arch_dest_regs(arch_dest_regs), .instr_valid(instr_valid), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an age-ordered list of pending instructions.
  typedef struct packed {
    logic [OPC_W-1:0]       opc;
    logic [ROB_W-1:0]       rob;
    logic [TAG_W-1:0]       dest;
    logic [TAG_W-1:0]       flg;
    logic [ARCH_W-1:0]      arch;
    logic [2:0][TAG_W-1:0]  tag;
    logic [2:0]             rdy;
    logic [2:0][DATA_W-1:0] val;
  } m_entry_t;

  m_entry_t          mq[$];
  logic              m_iv;
  logic [OPC_W-1:0]  m_opc;
  logic [ROB_W-1:0]  m_rob;
  logic [TAG_W-1:0]  m_dest, m_flg;
  logic [DATA_W-1:0] m_a, m_b, m_f;
  logic [ARCH_W-1:0] m_arch;

  function automatic m_entry_t wake(input m_entry_t e);
    m_entry_t r;
    r = e;
    if (cdb_valid) begin
      for (int k = 0; k < 3; k++) begin
        if (!r.rdy[k] && r.tag[k] == ((k == 2) ? cdb_flag_reg : cdb_dest_reg)) begin
          r.rdy[k] = 1'b1;
          r.val[k] = (k == 2) ? cdb_result_flags : cdb_result_val;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_iv = 1'b0; m_opc = '0; m_rob = '0; m_dest = '0; m_flg = '0;
    m_a = '0; m_b = '0; m_f = '0; m_arch = '0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then
  // step the DUT and land 1 time unit past the rising edge.
  task automatic cycle();
    m_entry_t e;
    int sel;
    bit room;
    room = (mq.size() < DEPTH);
    sel  = -1;
    foreach (mq[i]) if (sel < 0 && (&mq[i].rdy)) sel = i;
    if (flush) begin
      mq.delete();
      m_iv = 1'b0;
    end else begin
      m_iv = (sel >= 0);
      if (sel >= 0) begin
        e = mq[sel];
        m_opc = e.opc; m_rob = e.rob; m_dest = e.dest; m_flg = e.flg; m_arch = e.arch;
        m_a = e.val[0]; m_b = e.val[1]; m_f = e.val[2];
        mq.delete(sel);
      end
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (disp_valid && room) begin
        e.opc = disp_opcode; e.rob = disp_ROB_entry; e.dest = disp_dest_reg;
        e.flg = disp_flag_reg; e.arch = disp_arch_dest_regs;
        e.tag = {disp_f_tag, disp_b_tag, disp_a_tag};
        e.rdy = {disp_f_rdy, disp_b_rdy, disp_a_rdy};
        e.val = {disp_f_val, disp_b_val, disp_a_val};
        mq.push_back(wake(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  // Destination, flag register and arch mask are derived from the ROB index.
  task automatic set_disp(input logic [OPC_W-1:0] opc, input logic [ROB_W-1:0] rob,
                          input logic [2:0] rdy, input logic [14:0] tags,
                          input logic [23:0] vals);
    disp_valid          = 1'b1;
    disp_opcode         = opc;
    disp_ROB_entry      = rob;
    disp_dest_reg       = rob + 5'd1;
    disp_flag_reg       = rob + 5'd2;
    disp_arch_dest_regs = {rob, 3'b101};
    {disp_a_rdy, disp_b_rdy, disp_f_rdy} = rdy;
    {disp_a_tag, disp_b_tag, disp_f_tag} = tags;
    {disp_a_val, disp_b_val, disp_f_val} = vals;
  endtask

  task automatic set_cdb(input logic [TAG_W-1:0] dest, input logic [TAG_W-1:0] flg,
                         input logic [DATA_W-1:0] val, input logic [DATA_W-1:0] flags);
    cdb_valid        = 1'b1;
    cdb_dest_reg     = dest;
    cdb_flag_reg     = flg;
    cdb_result_val   = val;
    cdb_result_flags = flags;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_disp('0, '0, '0, '0, '0);
    disp_valid = 1'b0;
    set_cdb('0, '0, '0, '0);
    cdb_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_iv: got %b want 0", instr_valid); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", disp_ready); end
    checks++;
    if ({opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val, flags_val, arch_dest_regs} !== '0) begin
      errors++; $display("FAIL reset_data: got %h want 0",
        {opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val, flags_val, arch_dest_regs});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    set_disp(4'h5, 5'd3, 3'b111, {5'd0, 5'd0, 5'd0}, {8'h12, 8'h34, 8'h01});
    cycle(); idle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early: got %b want 0", instr_valid); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", count); end
    cycle();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_iv: got %b want 1", instr_valid); end
    checks++;
    if ({op_a_val, op_b_val, flags_val} !== 24'h123401) begin
      errors++; $display("FAIL basic_vals: got %h want 123401", {op_a_val, op_b_val, flags_val});
    end
    checks++;
    if ({opcode, ROB_entry, dest_reg, flag_reg, arch_dest_regs} !== {4'h5, 5'd3, 5'd4, 5'd5, 8'h1D}) begin
      errors++; $display("FAIL basic_fields: got %h want %h", {opcode, ROB_entry, dest_reg, flag_reg, arch_dest_regs},
        {4'h5, 5'd3, 5'd4, 5'd5, 8'h1D});
    end
    cycle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_one_shot: got %b want 0", instr_valid); end
    checks++; if (op_a_val !== 8'h12) begin errors++; $display("FAIL basic_hold: got %h want 12", op_a_val); end
  endtask

  task automatic test_cdb_wake();
    set_disp(4'h2, 5'd6, 3'b101, {5'd1, 5'd7, 5'd2}, {8'h11, 8'h00, 8'h22});
    cycle(); idle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wake_pre1: got %b want 0", instr_valid); end
    cycle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wake_pre2: got %b want 0", instr_valid); end
    set_cdb(5'd7, 5'd30, 8'h5A, 8'h00);
    cycle(); idle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wake_same_edge: got %b want 0", instr_valid); end
    cycle();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wake_iv: got %b want 1", instr_valid); end
    checks++;
    if ({op_a_val, op_b_val, flags_val, ROB_entry} !== {8'h11, 8'h5A, 8'h22, 5'd6}) begin
      errors++; $display("FAIL wake_vals: got %h want %h", {op_a_val, op_b_val, flags_val, ROB_entry},
        {8'h11, 8'h5A, 8'h22, 5'd6});
    end
    cycle();
  endtask

  task automatic test_full_ooo();
    for (int i = 0; i < 4; i++) begin
      set_disp(OPC_W'(i), ROB_W'(16 + i), 3'b011, {((i % 2) != 0) ? 5'd21 : 5'd20, 5'd0, 5'd0},
               {8'h00, 8'h40 + 8'(i), 8'h00});
      cycle();
    end
    idle();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (disp_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", disp_ready); end
    set_disp(4'hF, 5'd30, 3'b111, '0, {8'hAA, 8'hBB, 8'hCC});
    cycle(); idle();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL full_reject: got %0d want 4", count); end
    set_cdb(5'd21, 5'd31, 8'h99, 8'h00);
    cycle(); idle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ooo_early: got %b want 0", instr_valid); end
    cycle();
    checks++;
    if ({instr_valid, ROB_entry, op_a_val, count} !== {1'b1, 5'd17, 8'h99, 4'd3}) begin
      errors++; $display("FAIL ooo_first: got %h want %h", {instr_valid, ROB_entry, op_a_val, count},
        {1'b1, 5'd17, 8'h99, 4'd3});
    end
    cycle();
    checks++;
    if ({instr_valid, ROB_entry, op_b_val, count} !== {1'b1, 5'd19, 8'h43, 4'd2}) begin
      errors++; $display("FAIL ooo_second: got %h want %h", {instr_valid, ROB_entry, op_b_val, count},
        {1'b1, 5'd19, 8'h43, 4'd2});
    end
    cycle();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ooo_gap: got %b want 0", instr_valid); end
    set_cdb(5'd20, 5'd31, 8'h77, 8'h00);
    cycle(); idle();
    cycle();
    checks++; if ({instr_valid, ROB_entry} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL age_first: got %h want %h", {instr_valid, ROB_entry}, {1'b1, 5'd16}); end
    cycle();
    checks++; if ({instr_valid, ROB_entry, count} !== {1'b1, 5'd18, 4'd0}) begin
      errors++; $display("FAIL age_second: got %h want %h", {instr_valid, ROB_entry, count}, {1'b1, 5'd18, 4'd0}); end
    cycle();
  endtask

  task automatic test_bypass();
    set_disp(4'h9, 5'd9, 3'b110, {5'd3, 5'd4, 5'd9}, {8'h0A, 8'h0B, 8'h00});
    set_cdb(5'd31, 5'd9, 8'hEE, 8'h80);
    cycle(); idle();
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL bypass_count: got %0d want 1", count); end
    cycle();
    checks++;
    if ({instr_valid, flags_val, op_a_val} !== {1'b1, 8'h80, 8'h0A}) begin
      errors++; $display("FAIL bypass_issue: got %h want %h", {instr_valid, flags_val, op_a_val}, {1'b1, 8'h80, 8'h0A});
    end
    cycle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      set_disp(4'h3, ROB_W'(i + 1), 3'b011, {5'd25, 5'd0, 5'd0}, '0);
      cycle();
    end
    idle();
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL flush_fill: got %0d want 3", count); end
    set_disp(4'h7, 5'd12, 3'b111, '0, {8'h01, 8'h02, 8'h03});
    flush = 1'b1;
    cycle(); idle();
    checks++; if ({count, instr_valid} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL flush_clear: got %h want 0", {count, instr_valid}); end
    cycle();
    checks++; if ({count, instr_valid} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL flush_drop: got %h want 0", {count, instr_valid}); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      disp_valid          = ($urandom_range(0, 99) < 60);
      disp_opcode         = OPC_W'($urandom);
      disp_ROB_entry      = ROB_W'($urandom);
      disp_dest_reg       = TAG_W'($urandom);
      disp_flag_reg       = TAG_W'($urandom);
      disp_arch_dest_regs = ARCH_W'($urandom);
      disp_a_tag = TAG_W'($urandom_range(0, 7));
      disp_b_tag = TAG_W'($urandom_range(0, 7));
      disp_f_tag = TAG_W'($urandom_range(0, 7));
      disp_a_rdy = ($urandom_range(0, 99) < 50);
      disp_b_rdy = ($urandom_range(0, 99) < 50);
      disp_f_rdy = ($urandom_range(0, 99) < 60);
      disp_a_val = DATA_W'($urandom);
      disp_b_val = DATA_W'($urandom);
      disp_f_val = DATA_W'($urandom);
      cdb_valid        = ($urandom_range(0, 99) < 50);
      cdb_dest_reg     = TAG_W'($urandom_range(0, 7));
      cdb_flag_reg     = TAG_W'($urandom_range(0, 7));
      cdb_result_val   = DATA_W'($urandom);
      cdb_result_flags = DATA_W'($urandom);
      flush            = ($urandom_range(0, 99) < 3);
      cycle();
      checks++; if (instr_valid !== m_iv) begin errors++; $display("FAIL rnd_iv[%0d]: got %b want %b", n, instr_valid, m_iv); end
      checks++; if (count !== CNT_W'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", n, count, mq.size()); end
      checks++; if (disp_ready !== (mq.size() < DEPTH)) begin errors++; $display("FAIL rnd_ready[%0d]: got %b", n, disp_ready); end
      checks++;
      if ({opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val, flags_val, arch_dest_regs} !==
          {m_opc, m_rob, m_dest, m_flg, m_a, m_b, m_f, m_arch}) begin
        errors++; $display("FAIL rnd_data[%0d]: got %h want %h", n,
          {opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val, flags_val, arch_dest_regs},
          {m_opc, m_rob, m_dest, m_flg, m_a, m_b, m_f, m_arch});
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    flush = 1'b1;
    cycle(); idle();
    set_disp(4'hC, 5'd21, 3'b111, '0, {8'h5C, 8'h6D, 8'h7E});
    cycle(); idle();
    cycle();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", instr_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_iv: got %b want 0", instr_valid); end
    checks++;
    if ({count, opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val, flags_val, arch_dest_regs} !== '0) begin
      errors++; $display("FAIL rstmid_data: got %h want 0",
        {count, opcode, ROB_entry, dest_reg, flag_reg, op_a_val, op_b_val, flags_val, arch_dest_regs});
    end
    checks++; if (disp_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", disp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    checks++; if ({count, instr_valid} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL rstmid_after: got %h want 0", {count, instr_valid}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_cdb_wake();
    test_full_ooo();
    test_bypass();
    test_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
